wb_cmd_master: RTL and testbench

Single-clock Wishbone classic-cycle initiator that turns a valid/ready command stream into single Wishbone read or write cycles and returns one response per command. It is the initiator counterpart to the team's Wishbone RAM and peripheral responders, and is used by test harnesses, UART/SPI bridges and control FSMs that need bus access. One transaction is outstanding at a time; a programmable timeout prevents lock-up on an unresponsive responder.

---
 rtl/wb_cmd_master.sv | 161 ++++++++++++++++
 tb/tb_wb_cmd_master.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cmd_master.sv
// wb_cmd_master: Wishbone classic-cycle initiator driven by a valid/ready
// command stream. Each accepted command becomes one single read or write
// cycle and produces exactly one response; one transaction is outstanding.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   cmd_addr/data/sel/we/valid, cmd_ready   command stream in
//   rsp_data/err/timeout/valid, rsp_ready   response stream out
//   wb_adr_o/dat_o/we_o/sel_o/stb_o/cyc_o   Wishbone initiator outputs
//   wb_dat_i/ack_i/err_i                    Wishbone responder inputs
module wb_cmd_master #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned SELECT_WIDTH  = DATA_WIDTH / 8,
  parameter int unsigned TIMEOUT       = 256,
  parameter int unsigned TIMEOUT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ADDR_WIDTH-1:0]    cmd_addr,
  input  logic [DATA_WIDTH-1:0]    cmd_data,
  input  logic [SELECT_WIDTH-1:0]  cmd_sel,
  input  logic                     cmd_we,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  output logic [DATA_WIDTH-1:0]    rsp_data,
  output logic                     rsp_err,
  output logic                     rsp_timeout,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ADDR_WIDTH-1:0]    wb_adr_o,
  output logic [DATA_WIDTH-1:0]    wb_dat_o,
  input  logic [DATA_WIDTH-1:0]    wb_dat_i,
  output logic                     wb_we_o,
  output logic [SELECT_WIDTH-1:0]  wb_sel_o,
  output logic                     wb_stb_o,
  output logic                     wb_cyc_o,
  input  logic                     wb_ack_i,
  input  logic                     wb_err_i
);

  localparam bit TIMEOUT_EN = (TIMEOUT != 0);
  // Last counter value before the timeout fires; unused when TIMEOUT is 0.
  localparam logic [TIMEOUT_WIDTH-1:0] TO_LAST = TIMEOUT_WIDTH'(TIMEOUT - 32'd1);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t                    state, state_nxt;
  logic [TIMEOUT_WIDTH-1:0]  cnt, cnt_nxt;
  logic [ADDR_WIDTH-1:0]     adr_nxt;
  logic [DATA_WIDTH-1:0]     dat_nxt, rsp_data_nxt;
  logic [SELECT_WIDTH-1:0]   sel_nxt;
  logic                      we_nxt, stb_nxt, cyc_nxt;
  logic                      rsp_valid_nxt, rsp_err_nxt, rsp_timeout_nxt;
  logic                      expired, done;

  assign cmd_ready = (state == IDLE);
  assign expired   = TIMEOUT_EN && (cnt == TO_LAST);

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      wb_adr_o    <= '0;
      wb_dat_o    <= '0;
      wb_sel_o    <= '0;
      wb_we_o     <= 1'b0;
      wb_stb_o    <= 1'b0;
      wb_cyc_o    <= 1'b0;
      rsp_data    <= '0;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      wb_adr_o    <= adr_nxt;
      wb_dat_o    <= dat_nxt;
      wb_sel_o    <= sel_nxt;
      wb_we_o     <= we_nxt;
      wb_stb_o    <= stb_nxt;
      wb_cyc_o    <= cyc_nxt;
      rsp_data    <= rsp_data_nxt;
      rsp_valid   <= rsp_valid_nxt;
      rsp_err     <= rsp_err_nxt;
      rsp_timeout <= rsp_timeout_nxt;
    end
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (cmd_valid) state_nxt = BUS;
      BUS:  if (wb_err_i || wb_ack_i || expired) state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs and timeout counter
  always_comb begin
    cnt_nxt         = cnt;
    adr_nxt         = wb_adr_o;
    dat_nxt         = wb_dat_o;
    sel_nxt         = wb_sel_o;
    we_nxt          = wb_we_o;
    stb_nxt         = wb_stb_o;
    cyc_nxt         = wb_cyc_o;
    rsp_data_nxt    = rsp_data;
    rsp_valid_nxt   = rsp_valid;
    rsp_err_nxt     = rsp_err;
    rsp_timeout_nxt = rsp_timeout;
    done            = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          adr_nxt = cmd_addr;
          dat_nxt = cmd_data;
          sel_nxt = cmd_sel;
          we_nxt  = cmd_we;
          stb_nxt = 1'b1;
          cyc_nxt = 1'b1;
          cnt_nxt = '0;
        end
      end
      BUS: begin
        // ERR outranks ACK, which outranks the timeout.
        if (wb_err_i) begin
          rsp_err_nxt  = 1'b1;
          rsp_data_nxt = '0;
          done         = 1'b1;
        end else if (wb_ack_i) begin
          rsp_data_nxt = wb_we_o ? '0 : wb_dat_i;
          done         = 1'b1;
        end else if (expired) begin
          rsp_timeout_nxt = 1'b1;
          rsp_data_nxt    = '0;
          done            = 1'b1;
        end else if (TIMEOUT_EN) begin
          cnt_nxt = cnt + TIMEOUT_WIDTH'(1);
        end
        if (done) begin
          stb_nxt       = 1'b0;
          cyc_nxt       = 1'b0;
          we_nxt        = 1'b0;
          rsp_valid_nxt = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_nxt   = 1'b0;
          rsp_err_nxt     = 1'b0;
          rsp_timeout_nxt = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master: one instance with TIMEOUT=8, one with TIMEOUT=0,
// sharing a behavioural Wishbone RAM responder with programmable latency
// and ACK/ERR/silent modes.
module tb_wb_cmd_master;

  localparam int TO_A   = 8;
  localparam int M_ACK  = 0;
  localparam int M_NONE = 1;
  localparam int M_ERR  = 2;
  localparam int M_BOTH = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] cmd_addr = '0, cmd_data = '0;
  logic [3:0]  cmd_sel = '0;
  logic        cmd_we = 1'b0, cmd_valid = 1'b0, rsp_ready = 1'b0;
  logic        use1 = 1'b0;

  logic        ready0, ready1, rv0, rv1, re0, re1, rt0, rt1;
  logic [31:0] rd0, rd1, adr0, adr1, dato0, dato1;
  logic        we0, we1, stb0, stb1, cyc0, cyc1;
  logic [3:0]  sel0, sel1;
  logic        r_ack = 1'b0, r_err = 1'b0;
  logic [31:0] r_dat = '0;

  wb_cmd_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(TO_A), .TIMEOUT_WIDTH(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_sel(cmd_sel),
    .cmd_we(cmd_we), .cmd_valid(cmd_valid & ~use1), .cmd_ready(ready0), .rsp_data(rd0),
    .rsp_err(re0), .rsp_timeout(rt0), .rsp_valid(rv0), .rsp_ready(rsp_ready & ~use1),
    .wb_adr_o(adr0), .wb_dat_o(dato0), .wb_dat_i(r_dat), .wb_we_o(we0), .wb_sel_o(sel0),
    .wb_stb_o(stb0), .wb_cyc_o(cyc0), .wb_ack_i(r_ack & ~use1), .wb_err_i(r_err & ~use1));

  wb_cmd_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(0), .TIMEOUT_WIDTH(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_sel(cmd_sel),
    .cmd_we(cmd_we), .cmd_valid(cmd_valid & use1), .cmd_ready(ready1), .rsp_data(rd1),
    .rsp_err(re1), .rsp_timeout(rt1), .rsp_valid(rv1), .rsp_ready(rsp_ready & use1),
    .wb_adr_o(adr1), .wb_dat_o(dato1), .wb_dat_i(r_dat), .wb_we_o(we1), .wb_sel_o(sel1),
    .wb_stb_o(stb1), .wb_cyc_o(cyc1), .wb_ack_i(r_ack & use1), .wb_err_i(r_err & use1));

  // View of whichever instance is under test
  logic        m_ready, m_rv, m_re, m_rt, m_stb, m_cyc, m_we;
  logic [31:0] m_rd, m_adr, m_dato;
  logic [3:0]  m_sel;
  assign m_ready = use1 ? ready1 : ready0;
  assign m_rv    = use1 ? rv1 : rv0;
  assign m_re    = use1 ? re1 : re0;
  assign m_rt    = use1 ? rt1 : rt0;
  assign m_rd    = use1 ? rd1 : rd0;
  assign m_stb   = use1 ? stb1 : stb0;
  assign m_cyc   = use1 ? cyc1 : cyc0;
  assign m_we    = use1 ? we1 : we0;
  assign m_adr   = use1 ? adr1 : adr0;
  assign m_dato  = use1 ? dato1 : dato0;
  assign m_sel   = use1 ? sel1 : sel0;

  // Responder: after STB has been seen for resp_lat+1 edges, raise ACK/ERR for one cycle.
  int          resp_mode = M_NONE;
  int          resp_lat  = 0;
  int          wcnt = 0;
  logic [31:0] mem [32];
  always @(posedge clk) begin
    if (!m_stb) begin
      r_ack <= 1'b0; r_err <= 1'b0; wcnt <= 0;
    end else if (r_ack || r_err) begin
      r_ack <= 1'b0; r_err <= 1'b0; wcnt <= 0;
    end else if (resp_mode != M_NONE) begin
      if (wcnt == resp_lat) begin
        r_ack <= (resp_mode == M_ACK) || (resp_mode == M_BOTH);
        r_err <= (resp_mode == M_ERR) || (resp_mode == M_BOTH);
        r_dat <= mem[m_adr[6:2]];
        if (resp_mode == M_ACK && m_we)
          for (int b = 0; b < 4; b++)
            if (m_sel[b]) mem[m_adr[6:2]][8*b +: 8] <= m_dato[8*b +: 8];
      end else begin
        wcnt <= wcnt + 1;
      end
    end
  end

  int cyc_bad = 0;
  always @(negedge clk) if (rst_n && (stb0 !== cyc0 || stb1 !== cyc1)) cyc_bad <= cyc_bad + 1;

  int passed = 0, total = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  // One transaction; optionally holds rsp_ready low for `hold` cycles first.
  task automatic run_txn(input logic we, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input int md, input int lt, input int hold,
                         output logic [31:0] rd, output logic re, output logic rt, output int sn);
    int   guard;
    logic stable;
    resp_mode = md; resp_lat = lt;
    @(negedge clk);
    cmd_addr = a; cmd_data = d; cmd_sel = s; cmd_we = we; cmd_valid = 1'b1; rsp_ready = 1'b0;
    guard = 0;
    while (!m_ready && guard < 50) begin @(negedge clk); guard++; end
    if (!m_ready) chk("accept_bound", 0, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    sn = 0; guard = 0;
    while (!m_rv && guard < 3000) begin
      if (m_stb) sn++;
      @(negedge clk); guard++;
    end
    if (!m_rv) chk("rsp_bound", 0, 1);
    rd = m_rd; re = m_re; rt = m_rt;
    if (hold > 0) begin
      stable = 1'b1;
      cmd_valid = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        if (m_rv !== 1'b1 || m_rd !== rd || m_re !== re || m_rt !== rt || m_ready || m_stb)
          stable = 1'b0;
      end
      cmd_valid = 1'b0;
      chk("backpressure_stable", 64'(stable), 1);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("release_ready", 64'({m_ready, m_rv}), 64'(2'b10));
  endtask

  typedef struct {
    logic we; logic [31:0] addr; logic [31:0] data; logic [3:0] sel;
    int mode; int lat; logic [31:0] exp_data; logic exp_err; logic exp_to; int exp_stb;
  } vec_t;
  vec_t vecs[9];

  logic [31:0] ref_mem [32];
  logic [31:0] rd, ed, d, a;
  logic        re, rt, ee, et, w;
  logic [3:0]  s;
  int          sn, es, md, lt, r;

  initial begin
    for (int i = 0; i < 32; i++) begin mem[i] = '0; ref_mem[i] = '0; end

    vecs[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, M_ACK,  0, 32'h0,        1'b0, 1'b0, 2};
    vecs[1] = '{1'b0, 32'h10, 32'h0,        4'hF, M_ACK,  0, 32'hDEADBEEF, 1'b0, 1'b0, 2};
    vecs[2] = '{1'b1, 32'h14, 32'h11223344, 4'hF, M_ACK,  0, 32'h0,        1'b0, 1'b0, 2};
    vecs[3] = '{1'b1, 32'h14, 32'hAABBCCDD, 4'h5, M_ACK,  0, 32'h0,        1'b0, 1'b0, 2};
    vecs[4] = '{1'b0, 32'h14, 32'h0,        4'hF, M_ACK,  0, 32'h11BB33DD, 1'b0, 1'b0, 2};
    vecs[5] = '{1'b0, 32'h14, 32'h0,        4'hF, M_BOTH, 0, 32'h0,        1'b1, 1'b0, 2};
    vecs[6] = '{1'b1, 32'h14, 32'h55555555, 4'hF, M_NONE, 0, 32'h0,        1'b0, 1'b1, TO_A};
    vecs[7] = '{1'b0, 32'h14, 32'h0,        4'hF, M_ACK,  6, 32'h11BB33DD, 1'b0, 1'b0, TO_A};
    vecs[8] = '{1'b0, 32'h18, 32'h0,        4'hF, M_ERR,  3, 32'h0,        1'b1, 1'b0, 5};

    // Reset values
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ready", 64'(ready0), 1);
    chk("reset_outs", 64'({rv0, re0, rt0, stb0, cyc0, we0}), 0);
    chk("reset_regs", 64'({adr0, rd0}), 0);

    // Table-driven directed vectors
    for (int i = 0; i < 9; i++) begin
      run_txn(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].sel, vecs[i].mode, vecs[i].lat,
              0, rd, re, rt, sn);
      chk($sformatf("vec%0d_data", i), 64'(rd), 64'(vecs[i].exp_data));
      chk($sformatf("vec%0d_err", i), 64'(re), 64'(vecs[i].exp_err));
      chk($sformatf("vec%0d_to", i), 64'(rt), 64'(vecs[i].exp_to));
      chk($sformatf("vec%0d_stb", i), 64'(sn), 64'(vecs[i].exp_stb));
    end

    // Backpressure: response held 5 cycles with a new command waiting
    run_txn(1'b0, 32'h10, 32'h0, 4'hF, M_ACK, 0, 5, rd, re, rt, sn);
    chk("bp_data", 64'(rd), 64'h DEADBEEF);

    // TIMEOUT = 0 instance waits indefinitely for a late ACK
    use1 = 1'b1;
    run_txn(1'b0, 32'h10, 32'h0, 4'hF, M_ACK, 1000, 0, rd, re, rt, sn);
    chk("to0_data", 64'(rd), 64'hDEADBEEF);
    chk("to0_flags", 64'({re, rt}), 0);
    chk("to0_stb", 64'(sn), 1002);
    use1 = 1'b0;

    // Randomised transactions against a transaction-level memory model
    for (int n = 0; n < 60; n++) begin
      w  = 1'($urandom_range(0, 1));
      a  = 32'((16 + $urandom_range(0, 15)) * 4);
      d  = $urandom;
      s  = 4'($urandom_range(0, 15));
      r  = $urandom_range(0, 9);
      md = (r == 0) ? M_ERR : (r == 1) ? M_NONE : M_ACK;
      lt = $urandom_range(0, 6);
      ed = '0; ee = 1'b0; et = 1'b0; es = lt + 2;
      if (md == M_ERR) ee = 1'b1;
      else if (md == M_NONE) begin et = 1'b1; es = TO_A; end
      else if (w) begin
        for (int b = 0; b < 4; b++)
          if (s[b]) ref_mem[a[6:2]][8*b +: 8] = d[8*b +: 8];
      end else ed = ref_mem[a[6:2]];
      run_txn(w, a, d, s, md, lt, 0, rd, re, rt, sn);
      chk($sformatf("rnd%0d_data", n), 64'(rd), 64'(ed));
      chk($sformatf("rnd%0d_flags", n), 64'({re, rt}), 64'({ee, et}));
      chk($sformatf("rnd%0d_stb", n), 64'(sn), 64'(es));
    end

    // Async reset mid-BUS drops CYC/STB without a clock edge
    resp_mode = M_NONE;
    @(negedge clk);
    cmd_addr = 32'h20; cmd_we = 1'b0; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("rst_pre_stb", 64'(stb0), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("rst_async", 64'({stb0, cyc0}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_after", 64'({ready0, rv0}), 64'(2'b10));

    chk("cyc_eq_stb", 64'(cyc_bad), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
